// File: rtl/ultrasonic_stop_detect_pkg.sv
// Shared definitions for the ultrasonic stop path: ranger state
// encoding and the default timing constants reused by the game timers.
package ultrasonic_stop_detect_pkg;

    // System clock and ranging constants (58 us of round trip per cm).
    localparam int unsigned DEF_CLK_HZ        = 50_000_000;
    localparam int unsigned DEF_CYCLES_PER_CM = 2900;

    // Ranger sequencing defaults.
    localparam int unsigned DEF_TRIG_CYC  = 500;
    localparam int unsigned DEF_GAP_CYC   = 3_000_000;
    localparam int unsigned DEF_WAIT_CYC  = 1_500_000;
    localparam int unsigned DEF_MAX_CM    = 400;
    localparam int unsigned DEF_THRESH_CM = 10;
    localparam int unsigned DEF_NHITS     = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GAP       = 3'd4,
        DONE      = 3'd5
    } us_state_e;

    // Larger of two unsigned values; used to size shared cycle counters.
    function automatic int unsigned umax(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultrasonic_stop_detect_echo_sync.sv
// Two-flop synchronizer for the sensor echo line plus edge detection.
// Ports: clk_i, rst_ni (sync, active low), echo_i (async) -> rise_o, fall_o.
module ultrasonic_stop_detect_echo_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Edges are judged only on the synchronized copy.
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_stop_detect.sv
// HC-SR04 style ranger front-end: pings, measures echo width in cm and
// pulses stop after NHITS consecutive near pings.
// Ports: cin, resetn (sync, active low), enable, echo (async) in;
//        trig, stop, distance[8:0], dist_valid, no_target out.
module ultrasonic_stop_detect
    import ultrasonic_stop_detect_pkg::*;
#(
    parameter int unsigned CYCLES_PER_CM = DEF_CYCLES_PER_CM,
    parameter int unsigned TRIG_CYC      = DEF_TRIG_CYC,
    parameter int unsigned GAP_CYC       = DEF_GAP_CYC,
    parameter int unsigned WAIT_CYC      = DEF_WAIT_CYC,
    parameter int unsigned MAX_CM        = DEF_MAX_CM,
    parameter int unsigned THRESH_CM     = DEF_THRESH_CM,
    parameter int unsigned NHITS         = DEF_NHITS
) (
    input  logic       cin,
    input  logic       resetn,
    input  logic       enable,
    input  logic       echo,
    output logic       trig,
    output logic       stop,
    output logic [8:0] distance,
    output logic       dist_valid,
    output logic       no_target
);

    localparam int unsigned MAXCYC =
        umax(umax(CYCLES_PER_CM, TRIG_CYC), umax(GAP_CYC, WAIT_CYC));
    localparam int unsigned CW = $clog2(MAXCYC + 1);
    localparam int unsigned HW = $clog2(NHITS + 1);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SUB_LAST  = CW'(CYCLES_PER_CM - 1);
    localparam logic [8:0]    MAX_D     = 9'(MAX_CM);
    localparam logic [8:0]    THR_D     = 9'(THRESH_CM);
    localparam logic [HW-1:0] NHITS_D   = HW'(NHITS);

    logic echo_rise;
    logic echo_fall;

    ultrasonic_stop_detect_echo_sync u_echo_sync (
        .clk_i  (cin),
        .rst_ni (resetn),
        .echo_i (echo),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    us_state_e     state_q, state_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] sub_q, sub_d;
    logic [8:0]    cm_q, cm_d;
    logic [HW-1:0] hits_q, hits_d;
    logic          armed_q, armed_d;
    logic          trig_q, trig_d;
    logic          stop_q, stop_d;
    logic          dv_q, dv_d;
    logic [8:0]    dist_q, dist_d;
    logic          nt_q, nt_d;

    logic          wrap;
    logic [8:0]    cm_nxt;
    logic          done_go;
    logic          res_tmo;
    logic [8:0]    res_cm;
    logic          hit;

    // Sequencer. The result is latched on the transition into DONE so
    // distance, no_target and stop line up with the DONE cycle.
    always_comb begin
        state_d = state_q;
        per_d   = per_q + CW'(1);
        sub_d   = sub_q;
        cm_d    = cm_q;
        done_go = 1'b0;
        res_tmo = 1'b0;
        res_cm  = cm_q;
        wrap    = (sub_q == SUB_LAST);
        // The fall cycle itself still counts toward the width.
        cm_nxt  = cm_q + 9'(wrap);

        unique case (state_q)
            IDLE: begin
                per_d = '0;
                if (enable) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (per_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (per_q >= WAIT_LAST) begin
                    state_d = DONE;
                    done_go = 1'b1;
                    res_tmo = 1'b1;
                end
            end
            MEASURE: begin
                sub_d = wrap ? '0 : sub_q + CW'(1);
                cm_d  = cm_nxt;
                if (echo_fall) begin
                    state_d = DONE;
                    done_go = 1'b1;
                    res_cm  = cm_nxt;
                end else if (cm_nxt >= MAX_D) begin
                    // Out of range: give up without waiting for echo low.
                    state_d = DONE;
                    done_go = 1'b1;
                    res_tmo = 1'b1;
                end
            end
            DONE: begin
                state_d = GAP;
            end
            GAP: begin
                if (per_q >= GAP_LAST) begin
                    if (enable) begin
                        state_d = TRIG;
                        per_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                per_d   = '0;
            end
        endcase

        if (!enable) begin
            state_d = IDLE;
            per_d   = '0;
            done_go = 1'b0;
        end
    end

    // Result publication and hit/arm bookkeeping.
    always_comb begin
        hits_d  = hits_q;
        armed_d = armed_q;
        stop_d  = 1'b0;
        dv_d    = 1'b0;
        dist_d  = dist_q;
        nt_d    = nt_q;
        trig_d  = (state_d == TRIG);
        hit     = ~res_tmo & (res_cm < THR_D);

        if (done_go) begin
            dv_d   = 1'b1;
            dist_d = res_tmo ? MAX_D : res_cm;
            nt_d   = res_tmo;
            if (hit) begin
                if (hits_q != NHITS_D) begin
                    hits_d = hits_q + HW'(1);
                end
                // Fire once per presence; a far ping re-arms.
                if (hits_d == NHITS_D && armed_q) begin
                    stop_d  = 1'b1;
                    armed_d = 1'b0;
                end
            end else begin
                hits_d  = '0;
                armed_d = 1'b1;
            end
        end

        if (!enable) begin
            hits_d  = '0;
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge cin) begin
        if (!resetn) begin
            state_q <= IDLE;
            per_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            hits_q  <= '0;
            armed_q <= 1'b1;
            trig_q  <= 1'b0;
            stop_q  <= 1'b0;
            dv_q    <= 1'b0;
            dist_q  <= MAX_D;
            nt_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            hits_q  <= hits_d;
            armed_q <= armed_d;
            trig_q  <= trig_d;
            stop_q  <= stop_d;
            dv_q    <= dv_d;
            dist_q  <= dist_d;
            nt_q    <= nt_d;
        end
    end

    assign trig       = trig_q;
    assign stop       = stop_q;
    assign dist_valid = dv_q;
    assign distance   = dist_q;
    assign no_target  = nt_q;

endmodule

// File: tb/tb_ultrasonic_stop_detect.sv
// Scoreboard bench for ultrasonic_stop_detect with scaled-down timing.
// Stimulus pushes expected ping results; a monitor pops on dist_valid.
module tb_ultrasonic_stop_detect;

    localparam int CPC = 4;
    localparam int TRC = 3;
    localparam int GPC = 200;
    localparam int WTC = 60;
    localparam int MXC = 20;
    localparam int THC = 5;
    localparam int NHT = 2;

    logic       cin = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       echo = 1'b0;
    logic       trig;
    logic       stop;
    logic [8:0] distance;
    logic       dist_valid;
    logic       no_target;

    typedef struct {
        int d;
        int nt;
        int st;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise = 0;
    bit   have_last = 1'b0;
    logic prev_trig = 1'b0;

    always #5 cin = ~cin;

    ultrasonic_stop_detect #(
        .CYCLES_PER_CM (CPC),
        .TRIG_CYC      (TRC),
        .GAP_CYC       (GPC),
        .WAIT_CYC      (WTC),
        .MAX_CM        (MXC),
        .THRESH_CM     (THC),
        .NHITS         (NHT)
    ) dut (
        .cin        (cin),
        .resetn     (resetn),
        .enable     (enable),
        .echo       (echo),
        .trig       (trig),
        .stop       (stop),
        .distance   (distance),
        .dist_valid (dist_valid),
        .no_target  (no_target)
    );

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)",
                     nm, got, want, cyc);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge cin) begin : mon
        exp_t e;
        cyc++;
        if (resetn) begin
            chk("stop_only_with_dv", int'(stop & ~dist_valid), 0);
            if (dist_valid) begin
                chk("dv_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("distance", int'(distance), e.d);
                    chk("no_target", int'(no_target), e.nt);
                    chk("stop", int'(stop), e.st);
                    if (e.lat >= 0)
                        chk("dv_latency", cyc - last_rise, e.lat);
                end
            end
            if (trig && !prev_trig) begin
                if (have_last)
                    chk("trig_period", cyc - last_rise, GPC);
                last_rise = cyc;
                have_last = 1'b1;
            end
            if (!trig && prev_trig)
                chk("trig_width", cyc - last_rise, TRC);
        end
        prev_trig = trig;
    end

    // Wait for the next trig pulse to finish, then a few idle cycles.
    task automatic start_ping();
        int n;
        n = 0;
        while (trig !== 1'b1 && n < 500) begin
            @(negedge cin);
            n++;
        end
        chk("trig_seen", int'(trig === 1'b1), 1);
        n = 0;
        while (trig !== 1'b0 && n < 20) begin
            @(negedge cin);
            n++;
        end
        repeat (4) @(negedge cin);
    endtask

    task automatic ping(input int w, input int d, input int nt,
                        input int st, input int lat);
        exp_t e;
        e = '{d, nt, st, lat};
        sb.push_back(e);
        start_ping();
        if (w > 0) begin
            echo = 1'b1;
            repeat (w) @(negedge cin);
            echo = 1'b0;
        end
    endtask

    task automatic idle_checks(input string nm);
        chk({nm, "_trig"}, int'(trig), 0);
        chk({nm, "_dv"}, int'(dist_valid), 0);
        chk({nm, "_stop"}, int'(stop), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge cin);
        idle_checks("rst");
        chk("rst_distance", int'(distance), MXC);
        chk("rst_no_target", int'(no_target), 1);
        resetn = 1'b1;
        @(negedge cin);
        enable = 1'b1;

        // Far target: 28 cycles -> 7 cm, never stop.
        ping(28, 7, 0, 0, -1);
        ping(28, 7, 0, 0, -1);

        // Near/far sequence: stop on 2nd and 6th.
        ping(12, 3, 0, 0, -1);
        ping(12, 3, 0, 1, -1);
        ping(12, 3, 0, 0, -1);
        ping(28, 7, 0, 0, -1);
        ping(12, 3, 0, 0, -1);
        ping(12, 3, 0, 1, -1);

        // No echo: timeout 60 cycles after trig rise, re-arms.
        ping(0, 20, 1, 0, 60);
        ping(12, 3, 0, 0, -1);
        // 5 cm equals the threshold and is not a hit.
        ping(20, 5, 0, 0, -1);
        ping(12, 3, 0, 0, -1);
        ping(12, 3, 0, 1, -1);

        // Echo stuck high: saturates; spacing still checked by monitor.
        ping(100, 20, 1, 0, -1);
        ping(28, 7, 0, 0, -1);

        // One hit, then enable drops mid-measure: count must clear.
        ping(12, 3, 0, 0, -1);
        start_ping();
        echo = 1'b1;
        repeat (20) @(negedge cin);
        enable = 1'b0;
        have_last = 1'b0;
        repeat (10) begin
            @(negedge cin);
            idle_checks("dis");
        end
        echo = 1'b0;
        @(negedge cin);
        enable = 1'b1;
        // Distance 0 counts as a hit.
        ping(2, 0, 0, 0, -1);
        ping(12, 3, 0, 1, -1);

        // Reset mid-measure: no result, state cleared.
        ping(12, 3, 0, 0, -1);
        start_ping();
        echo = 1'b1;
        repeat (20) @(negedge cin);
        resetn = 1'b0;
        have_last = 1'b0;
        repeat (2) @(negedge cin);
        idle_checks("rst2");
        chk("rst2_distance", int'(distance), MXC);
        chk("rst2_no_target", int'(no_target), 1);
        echo = 1'b0;
        resetn = 1'b1;
        ping(12, 3, 0, 0, -1);
        ping(12, 3, 0, 1, -1);

        n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(negedge cin);
            n++;
        end
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_stop_detect.md
Name: ultrasonic_stop_detect

Overview:
- Upstream front-end for the game's stop path. It drives an HC-SR04-style ultrasonic ranger and measures the echo width in centimetres.
- It emits a single-cycle `stop` pulse when a hand is detected closer than a threshold for N consecutive pings.
- `stop` feeds the mode logic, which registers it as its stop/decide source when the ultrasonic stop option is selected.

Parameters:
- CYCLES_PER_CM, 2900, cin cycles per cm of range (58 us/cm at 50 MHz).
- TRIG_CYC, 500, trig high width in cycles (10 us).
- GAP_CYC, 3000000, minimum cycles from trig rise to next trig rise (60 ms).
- WAIT_CYC, 1500000, max cycles waiting for echo rise before declaring no-target.
- MAX_CM, 400, range saturation; echo longer than this is treated as no-target.
- THRESH_CM, 10, hit when distance < THRESH_CM.
- NHITS, 2, consecutive hits required to fire stop.

Ports:
- cin  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- enable  in  1  run pinging; low forces IDLE.
- echo  in  1  asynchronous echo from sensor.
- trig  out  1  trigger pulse to sensor.
- stop  out  1  one-cycle pulse on a confirmed near-target.
- distance  out  9  last measured range in cm, saturated at MAX_CM.
- dist_valid  out  1  one-cycle pulse when distance updates.
- no_target  out  1  level; last ping timed out or exceeded MAX_CM.

Behaviour:
- Reset (resetn low at posedge cin): the following are cleared.
  - trig, stop, dist_valid = 0.
  - distance = MAX_CM, no_target = 1.
  - state = IDLE, hit counter = 0, armed = 1.
  - All cycle counters = 0.
  - Reset mid-ping abandons the measurement, with no dist_valid.
- echo passes through a 2-FF synchronizer, so edges are seen 2 cycles late. Rise/fall are detected on the synchronized signal only.
- State machine:
  - IDLE: if enable, go to TRIG and start the period counter at 0.
  - TRIG: trig = 1 for exactly TRIG_CYC cycles, then WAIT_RISE.
  - WAIT_RISE: on echo rise go to MEASURE and clear the cm and sub-cm counters.
    - If the period counter since trig rise reaches WAIT_CYC first, mark timeout and go to DONE.
  - MEASURE: the sub-cm counter counts 0..CYCLES_PER_CM-1; on wrap, cm increments.
    - On echo fall go to DONE with result = cm.
    - If cm reaches MAX_CM while echo is still high, mark timeout and go to DONE. Echo low is not awaited.
  - DONE (1 cycle): dist_valid = 1.
    - Normal result: distance = cm, no_target = 0.
    - Timeout: distance = MAX_CM, no_target = 1.
    - Update the hit logic, then go to GAP.
  - GAP: wait until the period counter reaches GAP_CYC-1, then go to TRIG if enable, else IDLE.
    - In GAP, echo edges are ignored.
- Period counter: runs from trig rise until the next trig rise and is never reset elsewhere except by resetn/enable. Trig-to-trig spacing is exactly GAP_CYC when enable stays high.
- enable low in any state: next cycle state = IDLE and trig = 0.
  - Hit counter cleared, armed = 1.
  - distance/no_target hold their values.
  - No dist_valid or stop.
- Hit logic, evaluated in DONE only:
  - A hit is a valid (non-timeout) result with distance < THRESH_CM.
  - Hit: hit counter saturating-increments to NHITS.
  - Non-hit: hit counter = 0 and armed = 1.
  - stop pulses for one cycle, coincident with dist_valid, when the hit counter reaches NHITS and armed = 1; armed then clears.
  - Continuous presence therefore fires stop once; re-firing requires at least one far or timeout ping.
- Distance 0 (echo shorter than CYCLES_PER_CM) counts as a hit.
- Widths: cycle counters sized by $clog2 of the largest cycle parameter; cm counter 9 bits.

Decomposition:
- Shared game package holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GAP, DONE);
  - the default timing constants (CLK_HZ, CYCLES_PER_CM) reused by the reaction-time counter.
- One natural sub-module: echo_sync, the 2-FF synchronizer plus rise/fall edge detect.

Test Plan (override CYCLES_PER_CM=4, TRIG_CYC=3, GAP_CYC=200, WAIT_CYC=60, MAX_CM=20, THRESH_CM=5, NHITS=2):
- Reset then enable=1: trig high exactly 3 cycles; next trig rise exactly 200 cycles later.
- Echo high 28 cycles each ping: dist_valid with distance=7, no_target=0, never stop.
- Echo widths 12, 12, 12, 28, 12, 12 cycles (3 cm, 3 cm, 3 cm, 7 cm, 3 cm, 3 cm):
  - stop on ping 2 only while the 3 cm pings continue (none on ping 3);
  - re-arm on ping 4;
  - stop again on ping 6.
- No echo: after 60 cycles from trig rise, dist_valid, distance=20, no_target=1; hit counter cleared.
- Echo held high 100 cycles: saturates at 20 cm and times out; later echo fall is ignored; next trig still exactly 200 cycles after the previous one.
- enable low mid-MEASURE, or resetn low mid-MEASURE: IDLE next cycle, trig=0, no dist_valid/stop; a re-enable starts a fresh ping.
